aes256_rk_sched_ctrl: RTL and testbench
=======================================

Name: aes256_rk_sched_ctrl

Overview:
Controller that sequences the AES-256 key-expansion datapath. It latches a 256-bit cipher key and pulses the expander's start. It captures the 15 round keys the expander emits one per cycle into a local 15x128 store. It then streams them to the cipher round datapath in ascending order (encrypt) or descending order (decrypt) over a valid/ready handshake. It sits between the key-load register interface, the key-expansion instance and the AES round core.

Parameters:
NR, 14, number of rounds; the store holds NR+1 round keys (fixed at 14 for AES-256).
KEY_W, 256, cipher key width.
BLK_W, 128, round-key width.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
key_in  in  KEY_W  cipher key; sampled when key_load && key_load_rdy.
key_load  in  1  request to load a new key.
key_load_rdy  out  1  high when a key load is accepted (state IDLE or READY, no stream active).
keys_valid  out  1  store holds a complete schedule for the last accepted key.
exp_start  out  1  one-cycle start pulse to the expander.
exp_key  out  KEY_W  registered key driven to the expander; held stable for the whole expansion.
exp_subkey  in  BLK_W  expander round-key output.
exp_rdy  in  1  expander busy/valid flag.
sched_err  out  1  sticky; set if exp_rdy is low during any capture cycle 1..14.
rk_start  in  1  begin a round-key stream; accepted only when keys_valid && !stream_active.
rk_dec  in  1  sampled with rk_start; 0 = order RK0..RK14, 1 = order RK14..RK0.
rk_valid  out  1  round-key output valid.
rk_ready  in  1  consumer accepts rk_data.
rk_data  out  BLK_W  current round key.
rk_idx  out  4  index of the round key currently on rk_data.
rk_last  out  1  high with the 15th key of a stream.

Behaviour:
- Reset: state=IDLE; all outputs 0; store contents don't-care but keys_valid=0; exp_key=0; sched_err=0.
- FSM states: IDLE, START, EXPAND, READY.
- IDLE/READY, key_load && key_load_rdy at cycle T:
  - exp_key <= key_in; keys_valid <= 0; go to START.
- START (cycle T+1):
  - exp_start=1.
  - Expander presents RK0 combinationally this cycle; store[0] <= exp_subkey.
  - cap_idx <= 1; go to EXPAND.
- EXPAND (cycles T+2..T+15):
  - store[cap_idx] <= exp_subkey; cap_idx increments.
  - If exp_rdy==0 in any EXPAND cycle, set sched_err.
  - After capturing cap_idx==14 (cycle T+15): go to READY; keys_valid=1 from T+16.
  - exp_start stays 0 throughout EXPAND.
- key_load is ignored (key_load_rdy=0) in START and EXPAND, and while a stream is active.
- Streaming (READY only):
  - rk_start accepted at cycle S: idx <= rk_dec ? 14 : 0; rk_valid=1 from S+1.
  - rk_data = store[idx] (registered read or direct mux); rk_idx = idx.
  - Handshake: on rk_valid && rk_ready, idx steps ±1.
  - rk_valid, rk_data and rk_idx are held stable while rk_ready=0.
  - rk_last=1 when idx==14 (enc) or idx==0 (dec). On acceptance of the last key, rk_valid drops next cycle and the stream ends.
  - rk_start during an active stream is ignored. Back-to-back streams: a new rk_start may be accepted in the cycle after the last handshake.
  - No wrap-around: idx never leaves 0..14.
- keys_valid stays 1 across any number of streams until the next accepted key_load.
- Reset mid-expansion or mid-stream: immediate return to IDLE; rk_valid=0, keys_valid=0, exp_start=0. The expander is reset by the same signal.
- Simultaneous key_load and rk_start in READY: rk_start has priority; key_load waits (key_load_rdy=0 next cycle).

Decomposition:
- Shared AES package: NR, KEY_W, BLK_W, 4-bit round-index type, FSM state enum.
- One natural sub-module: aes_rk_store (15x128 register file, one write port, one read port, index-addressed).
- The expander is instantiated beside this block, not inside it.

Test Plan:
- FIPS-197 C.3 key 000102…1f loaded → keys_valid at T+16; store[0]=000102030405060708090a0b0c0d0e0f, store[1]=101112131415161718191a1b1c1d1e1f, store[2]=a573c29fa176c498a97fce93a572c09c, store[14]=24fc79ccbf0979e9371ac23c6d68de36.
- Encrypt stream with rk_ready always 1 → 15 consecutive beats, rk_idx 0..14, rk_last only on beat 15; decrypt stream → rk_idx 14..0, first beat data 24fc79cc…de36.
- Random rk_ready backpressure (stall 3 cycles at idx 7) → rk_data and rk_idx held at 7; no key skipped or duplicated.
- key_load pulsed at T+5 during EXPAND and during an active stream → ignored; schedule and stream unchanged; key_load_rdy=0 in both.
- Reset asserted at T+8 mid-expansion → next cycle all outputs 0, keys_valid=0; a following load of the same key gives an identical schedule.
- exp_rdy forced low at EXPAND cycle T+6 → sched_err=1 and stays set until reset.

Source files
------------

// File: rtl/aes256_rk_sched_ctrl_pkg.sv
// Shared AES-256 key-schedule types and sizes.
// Used by the schedule controller and its round-key store.
package aes256_rk_sched_ctrl_pkg;

    localparam int NR    = 14;
    localparam int KEY_W = 256;
    localparam int BLK_W = 128;
    localparam int NRK   = NR + 1;

    typedef logic [3:0] rk_idx_t;

    localparam rk_idx_t IDX_LAST = rk_idx_t'(NR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_EXPAND,
        S_READY
    } state_t;

endpackage

// File: rtl/aes_rk_store.sv
// 15 x 128 round-key register file.
// One synchronous write port, one combinational read port.
module aes_rk_store
    import aes256_rk_sched_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             i_we,
    input  rk_idx_t          i_waddr,
    input  logic [BLK_W-1:0] i_wdata,
    input  rk_idx_t          i_raddr,
    output logic [BLK_W-1:0] o_rdata
);

    logic [BLK_W-1:0] r_mem [NRK];

    // Capture one expander round key per write cycle.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/aes256_rk_sched_ctrl.sv
// AES-256 key-schedule controller: loads a key, captures the
// expander's 15 round keys and streams them forward or reversed.
module aes256_rk_sched_ctrl
    import aes256_rk_sched_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_load,
    output logic             key_load_rdy,
    output logic             keys_valid,
    output logic             exp_start,
    output logic [KEY_W-1:0] exp_key,
    input  logic [BLK_W-1:0] exp_subkey,
    input  logic             exp_rdy,
    output logic             sched_err,
    input  logic             rk_start,
    input  logic             rk_dec,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [BLK_W-1:0] rk_data,
    output logic [3:0]       rk_idx,
    output logic             rk_last
);

    state_t           r_state;
    state_t           w_next;
    logic [KEY_W-1:0] r_exp_key;
    logic             r_keys_valid;
    logic             r_sched_err;
    logic             r_rk_valid;
    logic             r_dec;
    rk_idx_t          r_cap_idx;
    rk_idx_t          r_idx;

    logic             w_we;
    rk_idx_t          w_waddr;
    logic [BLK_W-1:0] w_rdata;
    logic             w_idle_or_rdy;
    logic             w_start_acc;
    logic             w_load_acc;
    logic             w_hs;
    logic             w_last;

    assign w_idle_or_rdy = (r_state == S_IDLE)
                        || (r_state == S_READY);

    // A stream request beats a simultaneous key load.
    assign w_start_acc = rk_start && r_keys_valid
                      && !r_rk_valid
                      && (r_state == S_READY);

    assign key_load_rdy = w_idle_or_rdy && !r_rk_valid
                       && !w_start_acc;

    assign w_load_acc = key_load && key_load_rdy;
    assign w_hs       = r_rk_valid && rk_ready;
    assign w_last     = r_dec ? (r_idx == '0)
                              : (r_idx == IDX_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, expander start pulse and store write control.
    always_comb begin
        w_next    = r_state;
        exp_start = 1'b0;
        w_we      = 1'b0;
        w_waddr   = r_cap_idx;
        unique case (r_state)
            S_IDLE, S_READY: begin
                if (w_load_acc) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                exp_start = 1'b1;
                w_we      = 1'b1;
                w_waddr   = '0;
                w_next    = S_EXPAND;
            end
            S_EXPAND: begin
                w_we = 1'b1;
                if (r_cap_idx == IDX_LAST) begin
                    w_next = S_READY;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Key latch, capture counter, schedule-valid and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp_key    <= '0;
            r_keys_valid <= 1'b0;
            r_sched_err  <= 1'b0;
            r_cap_idx    <= '0;
        end else begin
            if (w_load_acc) begin
                r_exp_key    <= key_in;
                r_keys_valid <= 1'b0;
            end
            if (r_state == S_START) begin
                r_cap_idx <= rk_idx_t'(1);
            end
            if (r_state == S_EXPAND) begin
                r_cap_idx <= r_cap_idx + rk_idx_t'(1);
                if (!exp_rdy) begin
                    r_sched_err <= 1'b1;
                end
                if (r_cap_idx == IDX_LAST) begin
                    r_keys_valid <= 1'b1;
                end
            end
        end
    end

    // Round-key stream sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rk_valid <= 1'b0;
            r_dec      <= 1'b0;
            r_idx      <= '0;
        end else if (w_start_acc) begin
            r_rk_valid <= 1'b1;
            r_dec      <= rk_dec;
            r_idx      <= rk_dec ? IDX_LAST : '0;
        end else if (w_hs) begin
            if (w_last) begin
                r_rk_valid <= 1'b0;
            end else if (r_dec) begin
                r_idx <= r_idx - rk_idx_t'(1);
            end else begin
                r_idx <= r_idx + rk_idx_t'(1);
            end
        end
    end

    aes_rk_store u_store (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (exp_subkey),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

    assign keys_valid = r_keys_valid;
    assign exp_key    = r_exp_key;
    assign sched_err  = r_sched_err;
    assign rk_valid   = r_rk_valid;
    assign rk_idx     = r_idx;
    assign rk_data    = r_rk_valid ? w_rdata : '0;
    assign rk_last    = r_rk_valid && w_last;

endmodule

// File: tb/tb_aes256_rk_sched_ctrl.sv
// Bench for aes256_rk_sched_ctrl with a behavioural AES-256
// key-expansion model that also plays the expander role.
module tb_aes256_rk_sched_ctrl;

    logic         clk;
    logic         reset;
    logic [255:0] key_in;
    logic         key_load;
    logic         key_load_rdy;
    logic         keys_valid;
    logic         exp_start;
    logic [255:0] exp_key;
    logic [127:0] exp_subkey;
    logic         exp_rdy;
    logic         sched_err;
    logic         rk_start;
    logic         rk_dec;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_last;

    aes256_rk_sched_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .key_in       (key_in),
        .key_load     (key_load),
        .key_load_rdy (key_load_rdy),
        .keys_valid   (keys_valid),
        .exp_start    (exp_start),
        .exp_key      (exp_key),
        .exp_subkey   (exp_subkey),
        .exp_rdy      (exp_rdy),
        .sched_err    (sched_err),
        .rk_start     (rk_start),
        .rk_dec       (rk_dec),
        .rk_valid     (rk_valid),
        .rk_ready     (rk_ready),
        .rk_data      (rk_data),
        .rk_idx       (rk_idx),
        .rk_last      (rk_last)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]   sbox [256];
    logic [127:0] sched [15];
    logic [127:0] cap [15];
    logic [127:0] first_data;
    logic [3:0]   e_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expander stand-in: RK0 with the start pulse, then one per cycle.
    always @(posedge clk) begin
        if (reset) e_cnt <= 4'd0;
        else if (exp_start) e_cnt <= 4'd1;
        else if (e_cnt == 4'd14) e_cnt <= 4'd0;
        else if (e_cnt != 4'd0) e_cnt <= e_cnt + 4'd1;
    end

    assign exp_subkey = exp_start ? sched[0] : sched[e_cnt];

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x,
                                         input int n);
        logic [15:0] d = {x, x};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
            sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                    ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]],
                sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // FIPS-197 AES-256 key expansion into sched[0..14].
    task automatic expand_key(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++)
            sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        key_load = 1'b0;
        rk_start = 1'b0;
        rk_ready = 1'b0;
        exp_rdy = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Load a key; optionally pulse a competing load or drop exp_rdy.
    task automatic load_key(input logic [255:0] k, input int ig_at,
                            input int err_at, input logic exp_err);
        expand_key(k);
        key_in = k;
        key_load = 1'b1;
        #1;
        n_total++;
        if (key_load_rdy !== 1'b1)
            $display("FAIL load_rdy got %b want 1", key_load_rdy);
        else n_pass++;
        step();
        for (int c = 1; c <= 15; c++) begin
            key_load = (c == ig_at);
            if (c == ig_at) key_in = ~k;
            exp_rdy = (c != err_at);
            #1;
            if (c == 1) begin
                n_total++;
                if (exp_start !== 1'b1 || exp_key !== k)
                    $display("FAIL start_pulse got %b/%h want 1/%h",
                             exp_start, exp_key, k);
                else n_pass++;
            end
            if (c == 2) begin
                n_total++;
                if (exp_start !== 1'b0)
                    $display("FAIL start_once got %b want 0", exp_start);
                else n_pass++;
            end
            if (c == ig_at) begin
                n_total++;
                if (key_load_rdy !== 1'b0)
                    $display("FAIL busy_rdy got %b want 0", key_load_rdy);
                else n_pass++;
            end
            if (c == 15) begin
                n_total++;
                if (keys_valid !== 1'b0)
                    $display("FAIL kv_early got %b want 0", keys_valid);
                else n_pass++;
            end
            step();
        end
        key_load = 1'b0;
        exp_rdy = 1'b1;
        n_total++;
        if ({keys_valid, sched_err, exp_key} !== {1'b1, exp_err, k})
            $display("FAIL kv_t16 got %b/%b/%h want 1/%b/%h",
                     keys_valid, sched_err, exp_key, exp_err, k);
        else n_pass++;
    endtask

    // mode 0: always ready, 1: random, 2: random plus stall at key 7.
    task automatic run_stream(input logic dec, input int mode,
                              input logic noise, input logic with_load);
        int beats = 0;
        int cyc = 0;
        int stall = 0;
        logic [3:0] ei;
        logic forced;
        rk_start = 1'b1;
        rk_dec = dec;
        key_load = with_load;
        key_in = rnd256();
        #1;
        if (with_load) begin
            n_total++;
            if (key_load_rdy !== 1'b0)
                $display("FAIL prio_rdy got %b want 0", key_load_rdy);
            else n_pass++;
        end
        step();
        rk_start = 1'b0;
        key_load = 1'b0;
        rk_dec = 1'($urandom);
        n_total++;
        if (rk_valid !== 1'b1)
            $display("FAIL stream_valid got %b want 1", rk_valid);
        else n_pass++;
        while (beats < 15 && cyc < 300) begin
            ei = dec ? 4'(14 - beats) : 4'(beats);
            forced = (mode == 2) && (ei == 4'd7) && (stall < 3);
            if (forced) begin
                rk_ready = 1'b0;
                stall++;
            end else if (mode == 0) begin
                rk_ready = 1'b1;
            end else begin
                rk_ready = ($urandom_range(0, 3) != 0);
            end
            if (noise) begin
                rk_start = 1'($urandom);
                key_load = 1'($urandom);
                key_in = rnd256();
            end
            #1;
            if (noise && key_load) begin
                n_total++;
                if (key_load_rdy !== 1'b0)
                    $display("FAIL stream_rdy got %b want 0",
                             key_load_rdy);
                else n_pass++;
            end
            if (forced) begin
                n_total++;
                if ({rk_valid, rk_idx, rk_data} !== {1'b1, 4'd7, sched[7]})
                    $display("FAIL stall_hold got %b/%0d/%h want 1/7/%h",
                             rk_valid, rk_idx, rk_data, sched[7]);
                else n_pass++;
            end
            if (rk_ready) begin
                n_total++;
                if ({rk_valid, rk_idx, rk_data, rk_last} !==
                    {1'b1, ei, sched[ei], beats == 14})
                    $display("FAIL beat%0d got %b/%0d/%h/%b want 1/%0d/%h/%b",
                             beats, rk_valid, rk_idx, rk_data, rk_last,
                             ei, sched[ei], beats == 14);
                else n_pass++;
                if (beats == 0) first_data = rk_data;
                cap[ei] = rk_data;
                beats++;
            end
            step();
            cyc++;
        end
        rk_ready = 1'b0;
        rk_start = 1'b0;
        key_load = 1'b0;
        n_total++;
        if (beats != 15 || rk_valid !== 1'b0)
            $display("FAIL stream_end got beats %0d valid %b want 15/0",
                     beats, rk_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        n_total++;
        if ({keys_valid, exp_start, sched_err, rk_valid, rk_last,
             rk_idx, exp_key, rk_data} !== '0)
            $display("FAIL reset got kv%b st%b er%b v%b l%b i%0d k%h d%h want 0",
                     keys_valid, exp_start, sched_err, rk_valid,
                     rk_last, rk_idx, exp_key, rk_data);
        else n_pass++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_fips();
        logic [255:0] k = 256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
        logic [127:0] c2 = 128'ha573c29fa176c498a97fce93a572c09c;
        logic [127:0] c14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
        load_key(k, 0, 0, 1'b0);
        run_stream(1'b0, 0, 1'b0, 1'b0);
        n_total++;
        if (cap[0] !== k[255:128] || cap[1] !== k[127:0] ||
            cap[2] !== c2 || cap[14] !== c14)
            $display("FAIL fips_rk got %h %h %h %h", cap[0], cap[1],
                     cap[2], cap[14]);
        else n_pass++;
        run_stream(1'b1, 0, 1'b0, 1'b0);
        n_total++;
        if (first_data !== c14)
            $display("FAIL fips_dec_first got %h want %h",
                     first_data, c14);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_stream(1'b0, 0, 1'b0, 1'b0);
        run_stream(1'b1, 0, 1'b0, 1'b0);
        run_stream(1'b0, 0, 1'b0, 1'b0);
        n_total++;
        if (keys_valid !== 1'b1)
            $display("FAIL kv_sticky got %b want 1", keys_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        run_stream(1'b0, 2, 1'b0, 1'b0);
        run_stream(1'b1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_load();
        logic [255:0] k = rnd256();
        load_key(k, 5, 0, 1'b0);
        run_stream(1'b0, 1, 1'b1, 1'b0);
        run_stream(1'b1, 1, 1'b1, 1'b0);
        n_total++;
        if (exp_key !== k || keys_valid !== 1'b1)
            $display("FAIL ign_key got %h/%b want %h/1",
                     exp_key, keys_valid, k);
        else n_pass++;
    endtask

    task automatic test_priority();
        logic [255:0] k = exp_key;
        run_stream(1'b1, 1, 1'b0, 1'b1);
        n_total++;
        if (exp_key !== k || keys_valid !== 1'b1)
            $display("FAIL prio_key got %h/%b want %h/1",
                     exp_key, keys_valid, k);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [255:0] k = rnd256();
        expand_key(k);
        key_in = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        for (int c = 1; c < 8; c++) step();
        reset = 1'b1;
        step();
        n_total++;
        if ({keys_valid, exp_start, sched_err, rk_valid, rk_last,
             rk_idx, exp_key, rk_data} !== '0)
            $display("FAIL reset_mid got kv%b st%b v%b k%h want 0",
                     keys_valid, exp_start, rk_valid, exp_key);
        else n_pass++;
        reset = 1'b0;
        step();
        load_key(k, 0, 0, 1'b0);
        run_stream(1'b0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_sched_err();
        load_key(rnd256(), 0, 6, 1'b1);
        run_stream(1'b0, 1, 1'b0, 1'b0);
        load_key(rnd256(), 0, 0, 1'b1);
        n_total++;
        if (sched_err !== 1'b1)
            $display("FAIL err_sticky got %b want 1", sched_err);
        else n_pass++;
        do_reset();
        n_total++;
        if (sched_err !== 1'b0)
            $display("FAIL err_clear got %b want 0", sched_err);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            load_key(rnd256(), 0, 0, 1'b0);
            run_stream(1'($urandom), 1, 1'b1, 1'b0);
            run_stream(1'($urandom), 1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        key_in = '0;
        rk_dec = 1'b0;
        build_sbox();
        for (int r = 0; r < 15; r++) sched[r] = '0;
        do_reset();
        test_reset();
        test_fips();
        test_back_to_back();
        test_backpressure();
        test_ignored_load();
        test_priority();
        test_reset_mid();
        test_sched_err();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
